// File: rtl/lsb_stego_stream_embedder.sv
// Purpose: buffers a secret message, then streams one frame replacing the low cfg_nlsb bits of each sample with message bits.
// Latency: 1 cycle from accepted input sample to output sample (single output register).
// Backpressure: input is accepted only when the output register is empty or being drained; a stalled output holds its data.
module lsb_stego_stream_embedder #(
    parameter int WIDTH     = 500,
    parameter int HEIGHT    = 332,
    parameter int CHANNELS  = 3,
    parameter int DATA_W    = 8,
    parameter int MSG_DEPTH = 64,
    parameter int MAX_LSB   = 4
) (
    input  logic                             clk,
    input  logic                             HRESET,
    input  logic                             start,
    input  logic [2:0]                       cfg_nlsb,
    input  logic [$clog2(MSG_DEPTH+1)-1:0]   cfg_msg_len,
    input  logic                             msg_valid,
    input  logic [7:0]                       msg_data,
    output logic                             msg_ready,
    input  logic                             pix_in_valid,
    input  logic [DATA_W-1:0]                pix_in_data,
    output logic                             pix_in_ready,
    output logic                             pix_out_valid,
    output logic [DATA_W-1:0]                pix_out_data,
    output logic                             pix_out_last,
    input  logic                             pix_out_ready,
    output logic                             full_flag,
    output logic                             busy,
    output logic                             done,
    output logic                             cap_err
);

    localparam int NSAMP = WIDTH * HEIGHT * CHANNELS;
    localparam int LEN_W = $clog2(MSG_DEPTH + 1);
    localparam int AW    = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
    localparam int BIT_W = LEN_W + 3;
    localparam int CNT_W = $clog2(NSAMP + 1);
    localparam int MSG_W = 8 * MSG_DEPTH;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMBED, S_PASS} state_t;

    state_t             state_q, state_d;
    logic [2:0]         nlsb_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   wr_ptr_q;
    logic [BIT_W-1:0]   total_bits_q;
    logic [BIT_W-1:0]   bit_ptr_q;
    logic [CNT_W-1:0]   samp_cnt_q;
    logic               out_vld_q;
    logic [DATA_W-1:0]  out_dat_q;
    logic               out_last_q;
    logic               full_q;
    logic               done_q;
    logic               cap_err_q;
    logic [7:0]         msg_buf_q [MSG_DEPTH];

    logic               cfg_ok;
    logic               msg_hs;
    logic               in_hs;
    logic               out_hs;
    logic               in_is_last;
    logic               in_open;
    logic               last_byte;
    logic               msg_end;
    logic [BIT_W-1:0]   remaining;
    logic [3:0]         eff_n;
    logic [MSG_W-1:0]   msg_flat;
    logic [DATA_W-1:0]  win;
    logic [DATA_W-1:0]  mask;
    logic [DATA_W-1:0]  emb_dat;

    // Configuration legality: lane count, message length and total bit capacity of one frame.
    always_comb begin
        cfg_ok = (cfg_nlsb != 3'd0) && (int'(cfg_nlsb) <= MAX_LSB)
              && (cfg_msg_len != '0) && (int'(cfg_msg_len) <= MSG_DEPTH)
              && ((int'(cfg_msg_len) * 8) <= (NSAMP * int'(cfg_nlsb)));
    end

    assign msg_ready     = (state_q == S_LOAD);
    assign busy          = (state_q != S_IDLE);
    assign msg_hs        = msg_valid && msg_ready;
    assign last_byte     = (wr_ptr_q == len_q - LEN_W'(1));
    assign in_open       = (samp_cnt_q != CNT_W'(NSAMP));
    assign in_is_last    = (samp_cnt_q == CNT_W'(NSAMP - 1));
    assign pix_in_ready  = ((state_q == S_EMBED) || (state_q == S_PASS)) && in_open
                        && (!out_vld_q || pix_out_ready);
    assign in_hs         = pix_in_valid && pix_in_ready;
    assign out_hs        = out_vld_q && pix_out_ready;
    assign pix_out_valid = out_vld_q;
    assign pix_out_data  = out_dat_q;
    assign pix_out_last  = out_last_q;
    assign full_flag     = full_q;
    assign done          = done_q;
    assign cap_err       = cap_err_q;

    // Bit slicer: picks the next message bits (LSB-first across bytes) and trims the final partial group.
    always_comb begin
        msg_flat = '0;
        for (int b = 0; b < MSG_DEPTH; b++) begin
            msg_flat[b*8 +: 8] = msg_buf_q[b];
        end
        remaining = total_bits_q - bit_ptr_q;
        eff_n     = 4'd0;
        if (state_q == S_EMBED) begin
            if (remaining < BIT_W'(nlsb_q)) begin
                eff_n = 4'(remaining);
            end else begin
                eff_n = {1'b0, nlsb_q};
            end
        end
        msg_end = (remaining <= BIT_W'(nlsb_q));
        win     = DATA_W'(msg_flat >> bit_ptr_q);
        mask    = '0;
        for (int i = 0; i < DATA_W; i++) begin
            mask[i] = (i < int'(eff_n));
        end
        emb_dat = (pix_in_data & ~mask) | (win & mask);
    end

    // Next-state logic; a message ending on the final sample skips PASS and leaves from EMBED.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && cfg_ok) state_d = S_LOAD;
            S_LOAD:  if (msg_hs && last_byte) state_d = S_EMBED;
            S_EMBED: begin
                if (out_hs && out_last_q) begin
                    state_d = S_IDLE;
                end else if (in_hs && msg_end && !in_is_last) begin
                    state_d = S_PASS;
                end
            end
            S_PASS:  if (out_hs && out_last_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge HRESET) begin
        if (HRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Config capture, pointers, counters and status flags.
    always_ff @(posedge clk or posedge HRESET) begin
        if (HRESET) begin
            nlsb_q       <= '0;
            len_q        <= '0;
            wr_ptr_q     <= '0;
            total_bits_q <= '0;
            bit_ptr_q    <= '0;
            samp_cnt_q   <= '0;
            full_q       <= 1'b0;
            done_q       <= 1'b0;
            cap_err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            cap_err_q    <= 1'b0;
                            nlsb_q       <= cfg_nlsb;
                            len_q        <= cfg_msg_len;
                            total_bits_q <= {cfg_msg_len, 3'b000};
                            wr_ptr_q     <= '0;
                            bit_ptr_q    <= '0;
                            samp_cnt_q   <= '0;
                        end else begin
                            cap_err_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (msg_hs) begin
                        wr_ptr_q <= wr_ptr_q + LEN_W'(1);
                        if (last_byte) full_q <= 1'b1;
                    end
                end
                default: begin
                    if (in_hs) begin
                        samp_cnt_q <= samp_cnt_q + CNT_W'(1);
                        bit_ptr_q  <= bit_ptr_q + BIT_W'(eff_n);
                    end
                    if (out_hs && out_last_q) begin
                        done_q <= 1'b1;
                        full_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Message storage; contents are don't-care after reset so no reset branch.
    always_ff @(posedge clk) begin
        if (msg_hs) begin
            msg_buf_q[wr_ptr_q[AW-1:0]] <= msg_data;
        end
    end

    // Output register: loads on input handshake, empties on output handshake, holds while stalled.
    always_ff @(posedge clk or posedge HRESET) begin
        if (HRESET) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_last_q <= 1'b0;
        end else if (in_hs) begin
            out_vld_q  <= 1'b1;
            out_dat_q  <= emb_dat;
            out_last_q <= in_is_last;
        end else if (out_hs) begin
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
        end
    end

endmodule
